// File: rtl/wb_bus_arbiter_pkg.sv
// Shared encodings for the two-master Wishbone arbiter: FSM states,
// last-grant codes and the IDLE arbitration rule.
package wb_bus_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE  = 2'd0;
    localparam logic [1:0] ARB_GNT_I = 2'd1;
    localparam logic [1:0] ARB_GNT_D = 2'd2;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    // Round-robin pick: a lone requester wins; on a tie the master that was
    // not served last wins. No request keeps the arbiter idle.
    function automatic logic [1:0] arb_pick(input logic req_i,
                                            input logic req_d,
                                            input logic last_gnt);
        logic [1:0] pick;
        pick = ARB_IDLE;
        if (req_i && req_d) begin
            pick = (last_gnt == GNT_I) ? ARB_GNT_D : ARB_GNT_I;
        end else if (req_i) begin
            pick = ARB_GNT_I;
        end else if (req_d) begin
            pick = ARB_GNT_D;
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_bus_arbiter_timeout.sv
// Bus watchdog counter: held at zero while clear_i is high, counts enabled
// cycles and saturates at all-ones. fire_o pulses on the LIMIT-th enabled
// cycle after a clear. LIMIT = 0 disables firing entirely.
module wb_timeout_counter #(
    parameter int LIMIT = 1024,
    parameter int W     = 11
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic fire_o
);

    localparam int            FIRE_AT_INT = (LIMIT == 0) ? 0 : LIMIT - 1;
    localparam logic [W-1:0]  FIRE_AT     = FIRE_AT_INT[W-1:0];
    localparam bit            ARMED       = (LIMIT != 0);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear dominates, then saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fire_o = ARMED && enable_i && (cnt_q == FIRE_AT);

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master (instruction/data) to one-slave Wishbone classic arbiter.
// Round-robin, one transfer per grant, registered grant, optional watchdog
// that terminates a hung transfer with a one-cycle err to the owner.
module wb_bus_arbiter
    import wb_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TMO_W          = 11
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        iwbs_cyc_i,
    input  logic        iwbs_stb_i,
    input  logic [31:0] iwbs_addr_i,
    output logic [31:0] iwbs_dat_o,
    output logic        iwbs_ack_o,
    output logic        iwbs_err_o,
    input  logic        dwbs_cyc_i,
    input  logic        dwbs_stb_i,
    input  logic        dwbs_we_i,
    input  logic [3:0]  dwbs_sel_i,
    input  logic [31:0] dwbs_addr_i,
    input  logic [31:0] dwbs_dat_i,
    output logic [31:0] dwbs_dat_o,
    output logic        dwbs_ack_o,
    output logic        dwbs_err_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_addr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    logic [1:0] state_q, state_d;
    logic       last_gnt_q, last_gnt_d;
    logic       gnt_i, gnt_d;
    logic       tmo_en, tmo_fire;
    logic       slave_done;

    assign gnt_i      = (state_q == ARB_GNT_I);
    assign gnt_d      = (state_q == ARB_GNT_D);
    assign slave_done = wbm_ack_i || wbm_err_i;
    // The watchdog only runs while a grant is outstanding and unanswered.
    assign tmo_en     = (gnt_i || gnt_d) && !slave_done;

    wb_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES),
        .W     (TMO_W)
    ) u_tmo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (state_q == ARB_IDLE),
        .enable_i (tmo_en),
        .fire_o   (tmo_fire)
    );

    // Next state: arbitrate in IDLE, return to IDLE after every transfer,
    // abort, or watchdog expiry, remembering who was just served.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            ARB_IDLE: begin
                state_d = arb_pick(iwbs_cyc_i && iwbs_stb_i,
                                   dwbs_cyc_i && dwbs_stb_i, last_gnt_q);
            end
            ARB_GNT_I: begin
                if (!iwbs_cyc_i || slave_done || tmo_fire) begin
                    state_d    = ARB_IDLE;
                    last_gnt_d = GNT_I;
                end
            end
            ARB_GNT_D: begin
                if (!dwbs_cyc_i || slave_done || tmo_fire) begin
                    state_d    = ARB_IDLE;
                    last_gnt_d = GNT_D;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ARB_IDLE;
            last_gnt_q <= GNT_I;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
        end
    end

    // Bus mux and response routing; everything is zero outside a grant.
    // An ack that coincides with the owner dropping cyc is swallowed.
    always_comb begin
        wbm_cyc_o  = 1'b0;
        wbm_stb_o  = 1'b0;
        wbm_we_o   = 1'b0;
        wbm_sel_o  = 4'h0;
        wbm_addr_o = 32'h0;
        wbm_dat_o  = 32'h0;
        iwbs_dat_o = 32'h0;
        iwbs_ack_o = 1'b0;
        iwbs_err_o = 1'b0;
        dwbs_dat_o = 32'h0;
        dwbs_ack_o = 1'b0;
        dwbs_err_o = 1'b0;
        if (gnt_i) begin
            wbm_cyc_o  = iwbs_cyc_i && !tmo_fire;
            wbm_stb_o  = iwbs_stb_i && !tmo_fire;
            wbm_sel_o  = 4'hF;
            wbm_addr_o = iwbs_addr_i;
            iwbs_dat_o = wbm_dat_i;
            iwbs_ack_o = wbm_ack_i && iwbs_cyc_i;
            iwbs_err_o = wbm_err_i || tmo_fire;
        end else if (gnt_d) begin
            wbm_cyc_o  = dwbs_cyc_i && !tmo_fire;
            wbm_stb_o  = dwbs_stb_i && !tmo_fire;
            wbm_we_o   = dwbs_we_i;
            wbm_sel_o  = dwbs_sel_i;
            wbm_addr_o = dwbs_addr_i;
            wbm_dat_o  = dwbs_dat_i;
            dwbs_dat_o = wbm_dat_i;
            dwbs_ack_o = wbm_ack_i && dwbs_cyc_i;
            dwbs_err_o = wbm_err_i || tmo_fire;
        end
    end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Two-master to one-slave Wishbone (classic, single-transfer) arbiter.
- Lets the core's instruction port (iwbm_*) and data port (dwbm_*) share one external memory/interconnect port.
- Sits between core and the SoC bus.
- Round-robin grant, one transfer per grant, with an optional bus-timeout watchdog that terminates hung transfers with err.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles a granted transfer may wait for ack/err before the arbiter forces err. 0 disables the watchdog.
- TMO_W, 11: width of the timeout counter. Must satisfy 2^TMO_W > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- iwbs_cyc_i  in  1  instruction master cycle
- iwbs_stb_i  in  1  instruction master strobe
- iwbs_addr_i  in  32  instruction fetch address
- iwbs_dat_o  out  32  read data to instruction master
- iwbs_ack_o  out  1  ack to instruction master
- iwbs_err_o  out  1  err to instruction master
- dwbs_cyc_i  in  1  data master cycle
- dwbs_stb_i  in  1  data master strobe
- dwbs_we_i  in  1  data master write enable
- dwbs_sel_i  in  4  data master byte select
- dwbs_addr_i  in  32  data address
- dwbs_dat_i  in  32  data write data
- dwbs_dat_o  out  32  read data to data master
- dwbs_ack_o  out  1  ack to data master
- dwbs_err_o  out  1  err to data master
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  shared bus controls
- wbm_sel_o  out  4  shared byte select
- wbm_addr_o  out  32  shared address
- wbm_dat_o  out  32  shared write data
- wbm_dat_i  in  32  shared read data
- wbm_ack_i  in  1  shared ack
- wbm_err_i  in  1  shared err

Behaviour:
- States: IDLE, GNT_I, GNT_D. Registered: state, last_gnt (I/D), tmo_cnt.
- Reset (async, any cycle, including mid-transfer): state=IDLE, last_gnt=I, tmo_cnt=0. While in IDLE, all outputs are 0.
- IDLE arbitration, request = cyc_i&&stb_i:
  - only I requests -> GNT_I; only D requests -> GNT_D.
  - both request -> grant the master not equal to last_gnt. After reset D wins the first tie.
  - Grant is registered, so one cycle of arbitration latency. wbm_cyc_o first rises the cycle after the request is seen in IDLE.
- Granted state X: wbm_cyc_o = X_cyc_i && !tmo_fire; wbm_stb_o = X_stb_i && !tmo_fire.
  - addr/we/sel/dat are muxed combinationally from X.
  - For I: we=0, sel=4'hF, dat_o=0.
- Response routing:
  - X_ack_o = wbm_ack_i in state X; X_err_o = wbm_err_i || tmo_fire in state X.
  - X_dat_o = wbm_dat_i in state X, else 0.
  - The non-granted master always sees ack/err/dat = 0.
- Leaving a grant:
  - On wbm_ack_i or wbm_err_i or tmo_fire: last_gnt<=X, state<=IDLE. Every transfer is re-arbitrated, so there is one idle cycle between consecutive transfers.
  - If X drops cyc_i before ack (abort): state<=IDLE, last_gnt<=X, wbm_cyc_o drops in the same cycle. An ack arriving in that same cycle is not forwarded.
- Watchdog:
  - tmo_cnt clears on entry to any GNT state and increments each granted cycle without ack/err.
  - tmo_fire = (TIMEOUT_CYCLES!=0) && (tmo_cnt == TIMEOUT_CYCLES-1) && !wbm_ack_i && !wbm_err_i.
  - tmo_fire is a one-cycle err pulse to X.
  - Counter saturates and never wraps.
- Simultaneous ack and err from the slave: both are forwarded unchanged. Masters treat err as dominant.
- wbm_ack_i/wbm_err_i while in IDLE are ignored.

Decomposition:
- Shared defines header: state encodings (ARB_IDLE=2'd0, ARB_GNT_I=2'd1, ARB_GNT_D=2'd2) and GNT_I/GNT_D codes for last_gnt.
- One natural sub-module, wb_timeout_counter: clear, enable, fire, with parameterized limit and width. It is reusable for the core's stage_mem port.

Test Plan:
- Reset, then I only: iwbs cyc/stb=1, addr=0x8000_0000, slave acks 2 cycles after wbm_cyc_o with dat 0x00000013 -> wbm_cyc_o high cycle 1, iwbs_ack_o=1 with dat 0x13 in the ack cycle, dwbs_ack_o stays 0.
- Tie after reset: I and D request in the same cycle, D is a write of 0xDEADBEEF, sel=4'b0011, addr=0x100 -> D granted first with wbm_we_o=1, sel=0011. After ack: one IDLE cycle, then I granted.
- Fairness: both masters request continuously for 6 transfers -> grants alternate D,I,D,I,D,I. Neither master waits more than one transfer.
- Timeout with TIMEOUT_CYCLES=8, slave never acks -> exactly 8 granted cycles, then dwbs_err_o=1 for 1 cycle with wbm_cyc_o=0 in that cycle, then state IDLE.
- Abort: D drops cyc at cycle 2 of a grant while wbm_ack_i=1 in the same cycle -> dwbs_ack_o=0, wbm_cyc_o=0, next cycle IDLE. A pending I is granted the following cycle.
- Async reset mid-transfer: assert rst_i between clock edges during GNT_I -> all outputs 0 immediately. After release, the first tie goes to D.
